seq_det_prog: RTL and testbench
===============================

// Module: seq_det_prog
// PURPOSE
//  Runtime-programmable serial pattern detector; parametrised successor of the fixed 8-bit detector.
//  Shifts in a qualified serial bit stream and matches the last cfg_len bits against a programmed pattern.
//  Supports don't-care mask bits, overlapping or non-overlapping match modes and a saturating match counter.
//  Sits behind the serial front end; det_pulse feeds framing/alignment logic, det_count goes to status CSRs.
// PARAMETERS
//  MAX_LEN     16            max pattern length in bits (2..32); sets shift register and cfg widths
//  CNT_W       16            width of match counter det_count
//  RST_SEQ     16'h0099      pattern loaded at reset (MAX_LEN bits)
//  RST_LEN     8             pattern length loaded at reset (1..MAX_LEN)
//  LW          $clog2(MAX_LEN+1)  derived; width of length fields
// PORTS
//  clk          in   1        clock, all logic on rising edge
//  rst_n        in   1        reset, asynchronous assert, active-low
//  in_valid     in   1        in_data is a new stream bit this cycle
//  in_data      in   1        serial data bit
//  cfg_we       in   1        load cfg_* into active configuration
//  cfg_seq      in   MAX_LEN  pattern; bit [len-1] = oldest (first received) bit, bit 0 = newest
//  cfg_mask     in   MAX_LEN  1 = compare bit, 0 = don't care
//  cfg_len      in   LW       pattern length
//  cfg_overlap  in   1        1 = overlapping matches allowed, 0 = non-overlapping
//  clr_cnt      in   1        synchronous clear of det_count / cnt_sat
//  det_pulse    out  1        one-cycle pulse per match (registered)
//  det_count    out  CNT_W    number of matches since reset/clear, saturating
//  cnt_sat      out  1        sticky: det_count reached all-ones
//  cfg_err      out  1        one-cycle pulse: cfg_we rejected
// BEHAVIOUR
//  - Reset: sh_reg=0, fill=0, state FILL, seq=RST_SEQ, mask=all ones, len=RST_LEN, overlap=1;
//    det_pulse=0, det_count=0, cnt_sat=0, cfg_err=0.
//  - Accepted bit (in_valid=1, cfg_we=0): sh_reg <= {sh_reg[MAX_LEN-2:0], in_data}; fill <= min(fill+1, len).
//  - States: FILL (fill<len, no match possible; prevents false matches on reset zeros), ARMED (fill==len).
//    FILL->ARMED when accepted bit makes fill==len. ARMED->FILL only on non-overlap match or cfg load.
//  - Match condition evaluated on the post-shift value: fill_next==len and
//    ((sh_next ^ seq) & mask & ((1<<len)-1)) == 0. Bits above len ignored.
//  - Latency: det_pulse asserts the cycle after the clock edge that accepts the completing bit (1 cycle).
//    No match ever without an accepted bit; in_valid=0 holds all state.
//  - overlap=1: after match remain ARMED; next accepted bit may match again (e.g. all-ones pattern).
//    overlap=0: on match fill<=0, state FILL; next match needs len fresh bits.
//  - cfg_we: if 1<=cfg_len<=MAX_LEN, load seq/mask/len/overlap, clear sh_reg and fill, state FILL;
//    new config applies from next cycle. Otherwise ignore, keep old config, cfg_err pulse next cycle.
//    cfg_we wins over in_valid in the same cycle: that bit is dropped, no match reported.
//    det_count unaffected by cfg_we.
//  - det_count: +1 per match; saturates at 2^CNT_W-1, sets cnt_sat (sticky). clr_cnt clears both;
//    clr_cnt with simultaneous match -> det_count=1, cnt_sat=0.
//  - mask all zeros: every accepted bit in ARMED matches (legal, by design).
//  - rst_n asserted mid-stream: all state to reset values immediately; pending det_pulse lost.
// TESTING
//  1 Reset defaults, stream 1,0,0,1,1,0,0,1 (in_valid=1) -> single det_pulse 1 cycle after 8th bit, det_count=1.
//  2 After reset stream 8 zeros with RST_SEQ=0, len=8 -> no pulse on bits 1..7, pulse after bit 8 only.
//  3 cfg len=3 seq=3'b111 overlap=1, send 5 ones -> pulses after bits 3,4,5, count=3;
//    overlap=0 same stream -> pulse after bit 3 only, count=1 (bit 6 one -> second pulse).
//  4 len=4 seq=4'b1001 mask=4'b1001, stream 1,1,1,1 then 1,0,1,1 -> two pulses; gaps in in_valid hold state.
//  5 cfg_we cfg_len=0 and cfg_len=MAX_LEN+1 -> cfg_err pulses, matching with old config unchanged;
//    cfg_we same cycle as completing bit -> no pulse, fill=0.
//  6 CNT_W=4, 17 matches -> det_count=15, cnt_sat=1; clr_cnt with match -> det_count=1, cnt_sat=0;
//    rst_n low mid-pattern -> all outputs 0, pattern restarts from FILL.

Source files
------------

// File: rtl/seq_det_prog.sv
// Runtime-programmable serial pattern detector with don't-care mask, overlap
// control and a saturating match counter.
module seq_det_prog #(
  parameter int                 MAX_LEN = 16,
  parameter int                 CNT_W   = 16,
  parameter logic [MAX_LEN-1:0] RST_SEQ = MAX_LEN'('h0099),
  parameter int                 RST_LEN = 8,
  parameter int                 LW      = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic               in_data,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_seq,
  input  logic [MAX_LEN-1:0] cfg_mask,
  input  logic [LW-1:0]      cfg_len,
  input  logic               cfg_overlap,
  input  logic               clr_cnt,
  output logic               det_pulse,
  output logic [CNT_W-1:0]   det_count,
  output logic               cnt_sat,
  output logic               cfg_err
);

  typedef enum logic {S_FILL = 1'b0, S_ARMED = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t             r_state, w_state_next;
  logic [MAX_LEN-2:0] r_sh;
  logic [MAX_LEN-1:0] r_seq, r_mask;
  logic [LW-1:0]      r_len, r_fill;
  logic               r_overlap;
  logic               r_det_pulse, r_cfg_err, r_cnt_sat;
  logic [CNT_W-1:0]   r_cnt;

  logic [MAX_LEN-1:0] w_sh_next, w_len_mask;
  logic [LW-1:0]      w_fill_inc, w_fill_next;
  logic               w_accept, w_cfg_ok, w_cfg_load, w_fill_done, w_match;

  // A config write always steals the cycle, so the stream bit is dropped.
  assign w_accept   = in_valid & ~cfg_we;
  assign w_cfg_ok   = (cfg_len != '0) && ({1'b0, cfg_len} <= (LW+1)'(MAX_LEN));
  assign w_cfg_load = cfg_we & w_cfg_ok;
  // The oldest stored bit is never needed: the window is at most MAX_LEN incl. the new bit.
  assign w_sh_next  = {r_sh, in_data};
  assign w_fill_inc = (r_fill < r_len) ? r_fill + LW'(1) : r_len;

  genvar gi;
  generate
    for (gi = 0; gi < MAX_LEN; gi++) begin : g_len_mask
      assign w_len_mask[gi] = (r_len > LW'(gi));
    end
  endgenerate

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FILL;
      r_fill  <= '0;
    end else begin
      r_state <= w_state_next;
      r_fill  <= w_fill_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    w_fill_next  = r_fill;
    if (w_cfg_load) begin
      w_state_next = S_FILL;
      w_fill_next  = '0;
    end else if (w_accept) begin
      if (w_match && !r_overlap) begin
        w_state_next = S_FILL;
        w_fill_next  = '0;
      end else begin
        w_fill_next = w_fill_inc;
        if (w_fill_done) w_state_next = S_ARMED;
      end
    end
  end

  // Output (match) logic; evaluated on the post-shift window
  always_comb begin
    w_fill_done = w_accept && ((r_state == S_ARMED) || (w_fill_inc == r_len));
    w_match     = w_fill_done &&
                  (((w_sh_next ^ r_seq) & r_mask & w_len_mask) == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh      <= '0;
      r_seq     <= RST_SEQ;
      r_mask    <= '1;
      r_len     <= LW'(RST_LEN);
      r_overlap <= 1'b1;
    end else if (w_cfg_load) begin
      r_sh      <= '0;
      r_seq     <= cfg_seq;
      r_mask    <= cfg_mask;
      r_len     <= cfg_len;
      r_overlap <= cfg_overlap;
    end else if (w_accept) begin
      r_sh      <= w_sh_next[MAX_LEN-2:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_det_pulse <= 1'b0;
      r_cfg_err   <= 1'b0;
      r_cnt       <= '0;
      r_cnt_sat   <= 1'b0;
    end else begin
      r_det_pulse <= w_match;
      r_cfg_err   <= cfg_we & ~w_cfg_ok;
      if (clr_cnt) begin
        r_cnt     <= w_match ? CNT_W'(1) : '0;
        r_cnt_sat <= 1'b0;
      end else if (w_match && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + CNT_W'(1);
        if (r_cnt == CNT_MAX - CNT_W'(1)) r_cnt_sat <= 1'b1;
      end
    end
  end

  assign det_pulse = r_det_pulse;
  assign det_count = r_cnt;
  assign cnt_sat   = r_cnt_sat;
  assign cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_seq_det_prog.sv
// Directed bench for seq_det_prog: hand-computed pulse/count/error expectations.
module tb_seq_det_prog;
  localparam int MAX_LEN = 16;
  localparam int CNT_W   = 4;
  localparam int LW      = 5;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0, in_data = 1'b0;
  logic               cfg_we = 1'b0, cfg_overlap = 1'b0, clr_cnt = 1'b0;
  logic [MAX_LEN-1:0] cfg_seq = '0, cfg_mask = '0;
  logic [LW-1:0]      cfg_len = '0;
  logic               det_pulse, cnt_sat, cfg_err;
  logic [CNT_W-1:0]   det_count;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  seq_det_prog #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .cfg_we(cfg_we), .cfg_seq(cfg_seq), .cfg_mask(cfg_mask), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .clr_cnt(clr_cnt), .det_pulse(det_pulse),
    .det_count(det_count), .cnt_sat(cnt_sat), .cfg_err(cfg_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic send(input logic b, input logic exp_pulse);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    $display("txn bit=%0d pulse=%0d count=%0d sat=%0d", b, det_pulse, det_count, cnt_sat);
    check("pulse", {31'd0, det_pulse}, {31'd0, exp_pulse});
  endtask

  // bits[n-1] goes first; exp[i] is the pulse expected after bits[i]
  task automatic send_seq(input logic [31:0] bits, input int n, input logic [31:0] exp);
    for (int i = n - 1; i >= 0; i--) send(bits[i], exp[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check("idle_pulse", {31'd0, det_pulse}, 32'd0);
    end
  endtask

  task automatic cfg(input logic [15:0] seq, input logic [15:0] mask, input logic [4:0] len,
                     input logic ov, input logic exp_err);
    cfg_we = 1'b1; cfg_seq = seq; cfg_mask = mask; cfg_len = len; cfg_overlap = ov;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    $display("txn cfg seq=%0h mask=%0h len=%0d ov=%0d err=%0d", seq, mask, len, ov, cfg_err);
    check("cfg_err", {31'd0, cfg_err}, {31'd0, exp_err});
  endtask

  task automatic clr();
    clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    check("clr_count", {28'd0, det_count}, 32'd0);
  endtask

  task automatic check_cnt(input logic [3:0] exp_cnt, input logic exp_sat);
    check("count", {28'd0, det_count}, {28'd0, exp_cnt});
    check("sat", {31'd0, cnt_sat}, {31'd0, exp_sat});
  endtask

  initial begin
    #2;
    check("rst_pulse", {31'd0, det_pulse}, 32'd0);
    check_cnt(4'd0, 1'b0);
    check("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // reset pattern 1001_1001, len 8
    send_seq(32'b1001_1001, 8, 32'b0000_0001);
    check_cnt(4'd1, 1'b0);

    // all-zero pattern: reset zeros must not match before 8 bits
    clr();
    cfg(16'h0000, 16'hFFFF, 5'd8, 1'b1, 1'b0);
    send_seq(32'd0, 8, 32'b0000_0001);
    check_cnt(4'd1, 1'b0);

    // len 3 all-ones, overlapping then non-overlapping
    clr();
    cfg(16'h0007, 16'hFFFF, 5'd3, 1'b1, 1'b0);
    send_seq(32'b11111, 5, 32'b00111);
    check_cnt(4'd3, 1'b0);
    clr();
    cfg(16'h0007, 16'hFFFF, 5'd3, 1'b0, 1'b0);
    send_seq(32'b111111, 6, 32'b001001);
    check_cnt(4'd2, 1'b0);

    // masked 1xx1, non-overlap, with in_valid gaps
    clr();
    cfg(16'h0009, 16'h0009, 5'd4, 1'b0, 1'b0);
    send(1'b1, 1'b0); idle(2);
    send(1'b1, 1'b0); idle(1);
    send(1'b1, 1'b0);
    send(1'b1, 1'b1);
    send(1'b1, 1'b0);
    send(1'b0, 1'b0); idle(3);
    send(1'b1, 1'b0);
    send(1'b1, 1'b1);
    check_cnt(4'd2, 1'b0);

    // illegal lengths rejected, old config retained
    cfg(16'h0000, 16'h0000, 5'd0, 1'b1, 1'b1);
    idle(1);
    check("cfg_err_drop", {31'd0, cfg_err}, 32'd0);
    cfg(16'h0000, 16'h0000, 5'd17, 1'b1, 1'b1);
    send_seq(32'b1001, 4, 32'b0001);
    check_cnt(4'd3, 1'b0);

    // cfg_we on completing bit: bit dropped, fill cleared
    send_seq(32'b100, 3, 32'b000);
    cfg_we = 1'b1; cfg_seq = 16'h0009; cfg_mask = 16'h0009; cfg_len = 5'd4; cfg_overlap = 1'b0;
    in_valid = 1'b1; in_data = 1'b1;
    @(posedge clk); #1;
    cfg_we = 1'b0; in_valid = 1'b0;
    check("cfg_collide_pulse", {31'd0, det_pulse}, 32'd0);
    check("cfg_collide_err", {31'd0, cfg_err}, 32'd0);
    send_seq(32'b1001, 4, 32'b0001);
    check_cnt(4'd4, 1'b0);

    // saturation with a 1-bit pattern
    clr();
    cfg(16'h0001, 16'hFFFF, 5'd1, 1'b1, 1'b0);
    for (int i = 0; i < 14; i++) send(1'b1, 1'b1);
    check_cnt(4'd14, 1'b0);
    send(1'b1, 1'b1);
    check_cnt(4'd15, 1'b1);
    send(1'b1, 1'b1);
    send(1'b1, 1'b1);
    check_cnt(4'd15, 1'b1);
    clr_cnt = 1'b1; in_valid = 1'b1; in_data = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0; in_valid = 1'b0;
    check("clr_match_pulse", {31'd0, det_pulse}, 32'd1);
    check_cnt(4'd1, 1'b0);

    // async reset drops pending pulse and restores default config
    rst_n = 1'b0; #2;
    check("mid_rst_pulse", {31'd0, det_pulse}, 32'd0);
    check_cnt(4'd0, 1'b0);
    rst_n = 1'b1;
    send_seq(32'b1001100, 7, 32'd0);
    #2 rst_n = 1'b0; #2;
    check_cnt(4'd0, 1'b0);
    rst_n = 1'b1;
    send(1'b1, 1'b0);
    send_seq(32'b0011001, 7, 32'b0000001);
    check_cnt(4'd1, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
